inst_issue: RTL

Head-end instruction issuer for the instruction daisy chain. It accepts one configuration command per compute node from the host/controller side. Each command is serialized into IN chain words that load the node's local instruction registers, and the last word also carries the run flag. The block drives the first hop of the chain, tracks which nodes are running until they report done, and refuses new commands for a busy node.

---
 rtl/inst_issue.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/inst_issue.sv
// Head-end issuer for the instruction daisy chain: serializes one command per node
// into IN chain words, tracks which nodes are running, and flags spurious done pulses.
module inst_issue #(
    parameter int IW    = 36,
    parameter int IN    = 3,
    parameter int IRW   = 30,
    parameter int NODES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cmd_id,
    input  logic [IN*IRW-1:0]   cmd_inst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    output logic [IW-1:0]       inst_m_data,
    output logic                inst_m_valid,
    input  logic                inst_m_ready,
    input  logic [NODES-1:0]    node_done,
    output logic [NODES-1:0]    node_busy,
    output logic                all_idle,
    output logic                err_done,
    input  logic                err_clr
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [1:0] LAST_BEAT = 2'(IN - 1);
    localparam logic       SINGLE    = (IN == 1);

    state_t             r_state;
    logic [1:0]         r_id;
    logic [1:0]         r_beat;
    logic [IRW-1:0]     r_seg [4];
    logic [IW-1:0]      r_data;
    logic               r_valid;
    logic [NODES-1:0]   r_busy;
    logic               r_err;

    logic [IRW-1:0]     w_cmd_seg [4];
    logic [3:0]         w_busy_pad;
    logic [NODES-1:0]   w_set;
    logic [NODES-1:0]   w_clr;
    logic               w_spur;
    logic               w_cmd_ready;
    logic               w_accept;
    logic               w_hs;
    logic               w_last_hs;
    logic [1:0]         w_beat_nx;

    function automatic logic [IW-1:0] make_word(input logic run, input logic [1:0] id,
                                                input logic [1:0] addr, input logic [IRW-1:0] seg);
        return IW'({run, id, addr, 1'b0, seg});
    endfunction

    // Node slots beyond NODES read as permanently busy, so out-of-range ids are never accepted.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pad
            if (gi < IN) begin : g_seg
                assign w_cmd_seg[gi] = cmd_inst[IRW*gi +: IRW];
            end else begin : g_noseg
                assign w_cmd_seg[gi] = '0;
            end
            if (gi < NODES) begin : g_node
                assign w_busy_pad[gi] = r_busy[gi];
                assign w_set[gi]      = w_last_hs && (r_id == 2'(gi));
            end else begin : g_nonode
                assign w_busy_pad[gi] = 1'b1;
            end
        end
    endgenerate

    assign w_cmd_ready = (r_state == S_IDLE) && !w_busy_pad[cmd_id];
    assign w_accept    = cmd_valid && w_cmd_ready;
    assign w_hs        = (r_state == S_SEND) && r_valid && inst_m_ready;
    assign w_last_hs   = w_hs && (r_beat == LAST_BEAT);
    assign w_beat_nx   = r_beat + 2'd1;
    assign w_clr       = node_done & r_busy;
    assign w_spur      = |(node_done & ~r_busy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_id    <= 2'd0;
            r_beat  <= 2'd0;
            r_data  <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_seg[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id    <= cmd_id;
                        r_beat  <= 2'd0;
                        r_data  <= make_word(SINGLE, cmd_id, 2'd0, w_cmd_seg[0]);
                        r_valid <= 1'b1;
                        r_state <= S_SEND;
                        for (int i = 0; i < 4; i++) begin
                            r_seg[i] <= w_cmd_seg[i];
                        end
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (r_beat == LAST_BEAT) begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= w_beat_nx;
                            r_data <= make_word(w_beat_nx == LAST_BEAT, r_id, w_beat_nx,
                                                r_seg[w_beat_nx]);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A spurious done wins over a simultaneous clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (r_busy | w_set) & ~w_clr;
            if (w_spur) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign cmd_ready    = w_cmd_ready;
    assign inst_m_data  = r_data;
    assign inst_m_valid = r_valid;
    assign node_busy    = r_busy;
    assign all_idle     = (r_state == S_IDLE) && (r_busy == '0);
    assign err_done     = r_err;

endmodule
